// File: rtl/hmnoc_ctrl_pkg.sv
// hmnoc_ctrl_pkg: shared control-plane types for the cluster load controller and router.
//   cl_state_e : cluster_load_ctrl FSM states
//   dir_e      : router port directions
//   cnt_width  : counter width needed to index n items (minimum 1 bit)
package hmnoc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_WGHT,
        LD_IACT,
        WAIT_LOAD,
        START,
        COMPUTE,
        WRBACK,
        DONE
    } cl_state_e;

    typedef enum logic [2:0] {
        DIR_LOCAL,
        DIR_NORTH,
        DIR_SOUTH,
        DIR_EAST,
        DIR_WEST
    } dir_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glb_addr_seq.sv
// glb_addr_seq: GLB address sequencer, counts LEN steps from BASE while en is high.
//   clk, reset : clock, async active-high reset (clears the count)
//   en         : advance one address this cycle
//   addr       : BASE + count, wrapping modulo 2^ADDR_WIDTH
//   last       : the current address is the final one of the run
// The count returns to zero after the last step, so every run starts at BASE.
module glb_addr_seq
    import hmnoc_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int BASE       = 0,
    parameter int LEN        = 1,
    localparam int CW        = cnt_width(LEN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic [CW-1:0] idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idx <= '0;
        else if (en)
            idx <= last ? '0 : idx + 1'b1;
    end

    assign last = idx == CW'(LEN - 1);
    assign addr = ADDR_WIDTH'(BASE) + ADDR_WIDTH'(idx);

endmodule

// File: rtl/cluster_load_ctrl.sv
// cluster_load_ctrl: sequences one PE-cluster pass: load weights, load iacts, start, write back psums.
//   go                                   : start a pass (only looked at in IDLE)
//   read_req_*/r_addr_*                  : GLB read strobes and addresses
//   west_enable_i_*/load_en_*            : read strobes delayed by the 1-cycle GLB latency
//   load_done, compute_done              : handshakes from the PE cluster
//   start                                : one-cycle compute start pulse
//   pe_out                               : X_dim column results, captured on compute_done
//   west_data_i_psum/west_enable_i_psum/w_addr_psum : psum write-back to the router/GLB
//   busy, done                           : not-IDLE flag and end-of-pass pulse
module cluster_load_ctrl
    import hmnoc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 9,
    parameter int X_dim          = 3,
    parameter int NUM_WGHT       = 9,
    parameter int NUM_IACT       = 25,
    parameter int W_READ_ADDR    = 0,
    parameter int A_READ_ADDR    = 0,
    parameter int PSUM_LOAD_ADDR = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             go,
    output logic                             read_req_wght,
    output logic                             read_req_iact,
    output logic [ADDR_WIDTH-1:0]            r_addr_wght,
    output logic [ADDR_WIDTH-1:0]            r_addr_iact,
    output logic                             west_enable_i_wght,
    output logic                             west_enable_i_iact,
    output logic                             load_en_wght,
    output logic                             load_en_act,
    input  logic                             load_done,
    output logic                             start,
    input  logic                             compute_done,
    input  logic [X_dim-1:0][DATA_WIDTH-1:0] pe_out,
    output logic [DATA_WIDTH-1:0]            west_data_i_psum,
    output logic                             west_enable_i_psum,
    output logic [ADDR_WIDTH-1:0]            w_addr_psum,
    output logic                             busy,
    output logic                             done
);

    cl_state_e state, next;
    logic wght_d, iact_d;
    logic w_last, i_last, p_last;
    logic [ADDR_WIDTH-1:0] w_addr, i_addr, p_addr;
    logic [X_dim-1:0][DATA_WIDTH-1:0] psum_q;

    glb_addr_seq #(.ADDR_WIDTH(ADDR_WIDTH), .BASE(W_READ_ADDR), .LEN(NUM_WGHT)) u_wght_seq (
        .clk(clk), .reset(reset), .en(read_req_wght), .addr(w_addr), .last(w_last)
    );

    glb_addr_seq #(.ADDR_WIDTH(ADDR_WIDTH), .BASE(A_READ_ADDR), .LEN(NUM_IACT)) u_iact_seq (
        .clk(clk), .reset(reset), .en(read_req_iact), .addr(i_addr), .last(i_last)
    );

    glb_addr_seq #(.ADDR_WIDTH(ADDR_WIDTH), .BASE(PSUM_LOAD_ADDR), .LEN(X_dim)) u_psum_seq (
        .clk(clk), .reset(reset), .en(west_enable_i_psum), .addr(p_addr), .last(p_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wght_d <= 1'b0;
            iact_d <= 1'b0;
            psum_q <= '0;
        end else begin
            state  <= next;
            wght_d <= read_req_wght;
            iact_d <= read_req_iact;
            // word 0 is always the one being written back; shift the rest down each WRBACK cycle
            if (state == COMPUTE && compute_done)
                psum_q <= pe_out;
            else if (state == WRBACK)
                psum_q <= psum_q >> DATA_WIDTH;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:      next = go           ? LD_WGHT   : IDLE;
            LD_WGHT:   next = w_last       ? LD_IACT   : LD_WGHT;
            LD_IACT:   next = i_last       ? WAIT_LOAD : LD_IACT;
            WAIT_LOAD: next = load_done    ? START     : WAIT_LOAD;
            START:     next = COMPUTE;
            COMPUTE:   next = compute_done ? WRBACK    : COMPUTE;
            WRBACK:    next = p_last       ? DONE      : WRBACK;
            default:   next = IDLE;
        endcase
    end

    assign read_req_wght      = state == LD_WGHT;
    assign read_req_iact      = state == LD_IACT;
    assign r_addr_wght        = read_req_wght ? w_addr : '0;
    assign r_addr_iact        = read_req_iact ? i_addr : '0;
    assign west_enable_i_wght = wght_d;
    assign load_en_wght       = wght_d;
    assign west_enable_i_iact = iact_d;
    assign load_en_act        = iact_d;
    assign start              = state == START;
    assign west_enable_i_psum = state == WRBACK;
    assign west_data_i_psum   = west_enable_i_psum ? psum_q[0] : '0;
    assign w_addr_psum        = west_enable_i_psum ? p_addr : '0;
    assign busy               = state != IDLE;
    assign done               = state == DONE;

endmodule

// File: tb/tb_cluster_load_ctrl.sv
// tb_cluster_load_ctrl: scoreboard bench for cluster_load_ctrl (default and wrapping-base instances).
module tb_cluster_load_ctrl;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam int XD = 3;
    localparam int NW = 9;
    localparam int NI = 25;
    localparam int NP = 128;
    localparam int NK = 9;

    typedef struct {
        int t;
        int a;
        int d;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go = 1'b0;
    logic load_done = 1'b1;
    logic compute_done = 1'b0;
    logic [XD-1:0][DW-1:0] pe_out = '0;

    logic rq_w[2], rq_i[2], we_w[2], we_i[2], le_w[2], le_a[2], st[2], we_p[2], bsy[2], dn[2];
    logic [AW-1:0] ra_w[2], ra_i[2], wa_p[2];
    logic [DW-1:0] wd_p[2];

    exp_t q[2][NK][$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_lo = -1;
    int busy_hi = -2;
    string kname[NK] = '{"wght_rd", "iact_rd", "wght_west_en", "iact_west_en", "wght_load_en",
                         "act_load_en", "start", "psum_wr", "done"};

    cluster_load_ctrl dut0 (
        .clk(clk), .reset(reset), .go(go),
        .read_req_wght(rq_w[0]), .read_req_iact(rq_i[0]), .r_addr_wght(ra_w[0]), .r_addr_iact(ra_i[0]),
        .west_enable_i_wght(we_w[0]), .west_enable_i_iact(we_i[0]), .load_en_wght(le_w[0]), .load_en_act(le_a[0]),
        .load_done(load_done), .start(st[0]), .compute_done(compute_done), .pe_out(pe_out),
        .west_data_i_psum(wd_p[0]), .west_enable_i_psum(we_p[0]), .w_addr_psum(wa_p[0]),
        .busy(bsy[0]), .done(dn[0])
    );

    cluster_load_ctrl #(.W_READ_ADDR(505), .A_READ_ADDR(500), .PSUM_LOAD_ADDR(511)) dut1 (
        .clk(clk), .reset(reset), .go(go),
        .read_req_wght(rq_w[1]), .read_req_iact(rq_i[1]), .r_addr_wght(ra_w[1]), .r_addr_iact(ra_i[1]),
        .west_enable_i_wght(we_w[1]), .west_enable_i_iact(we_i[1]), .load_en_wght(le_w[1]), .load_en_act(le_a[1]),
        .load_done(load_done), .start(st[1]), .compute_done(compute_done), .pe_out(pe_out),
        .west_data_i_psum(wd_p[1]), .west_enable_i_psum(we_p[1]), .w_addr_psum(wa_p[1]),
        .busy(bsy[1]), .done(dn[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wb(input int d);
        return d == 0 ? 0 : 505;
    endfunction

    function automatic int ab(input int d);
        return d == 0 ? 0 : 500;
    endfunction

    function automatic int pb(input int d);
        return d == 0 ? 0 : 511;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp_v);
        end
    endtask

    task automatic push(input int d, input int k, input int t, input int a, input int dt);
        exp_t e;
        e.t = t;
        e.a = a;
        e.d = dt;
        q[d][k].push_back(e);
    endtask

    task automatic chk_evt(input int d, input int k, input logic s, input int a, input int dt);
        exp_t e;
        string nm;
        nm = $sformatf("dut%0d %s @%0d", d, kname[k], cyc);
        if (s) begin
            if (q[d][k].size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s unexpected strobe: got 1 required 0", nm);
            end else begin
                e = q[d][k].pop_front();
                cmp({nm, " cycle"}, cyc, e.t);
                cmp({nm, " addr"}, a, e.a);
                cmp({nm, " data"}, dt, e.d);
            end
        end else begin
            if (q[d][k].size() != 0 && q[d][k][0].t <= cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s missing strobe: got 0 required 1", nm);
                void'(q[d][k].pop_front());
            end
            cmp({nm, " idle value"}, a | dt, 0);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk_evt(d, 0, rq_w[d], int'(ra_w[d]), 0);
            chk_evt(d, 1, rq_i[d], int'(ra_i[d]), 0);
            chk_evt(d, 2, we_w[d], 0, 0);
            chk_evt(d, 3, we_i[d], 0, 0);
            chk_evt(d, 4, le_w[d], 0, 0);
            chk_evt(d, 5, le_a[d], 0, 0);
            chk_evt(d, 6, st[d], 0, 0);
            chk_evt(d, 7, we_p[d], int'(wa_p[d]), int'(wd_p[d]));
            chk_evt(d, 8, dn[d], 0, 0);
            cmp($sformatf("dut%0d busy @%0d", d, cyc), int'(bsy[d]), int'(cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        int r;
        r = cyc;
        reset = 1'b1;
        go = 1'b0;
        load_done = 1'b0;
        compute_done = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < NK; k++)
                while (q[d][k].size() != 0 && q[d][k][$].t >= r)
                    void'(q[d][k].pop_back());
        busy_hi = r - 1;
        #1;
        for (int d = 0; d < 2; d++)
            cmp($sformatf("dut%0d outputs in reset @%0d (ones)", d, cyc),
                $countones({rq_w[d], rq_i[d], we_w[d], we_i[d], le_w[d], le_a[d], st[d], we_p[d], bsy[d], dn[d],
                            ra_w[d], ra_i[d], wa_p[d], wd_p[d]}), 0);
        tick;
        tick;
        reset = 1'b0;
        repeat (3) tick;
    endtask

    // mode 0: load_done always high, pe_out={3,7,11}; mode 1: go held high all pass; mode 2: random
    task automatic run_pass(input int mode, input int rst_at);
        logic ldv[NP], cdv[NP], gov[NP];
        logic [XD-1:0][DW-1:0] pev[NP];
        int c, o_ld, o_cd, o_end;
        c = cyc;
        for (int o = 0; o < NP; o++) begin
            ldv[o] = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            cdv[o] = $urandom_range(0, 3) == 0;
            gov[o] = (mode == 1) ? 1'b1 : ($urandom_range(0, 1) == 1);
            for (int x = 0; x < XD; x++)
                pev[o][x] = (mode == 0) ? DW'(3 + 4 * x) : DW'($urandom);
        end
        ldv[60] = 1'b1;
        o_ld = NW + NI + 1;
        while (!ldv[o_ld]) o_ld++;
        cdv[o_ld + 22] = 1'b1;
        o_cd = o_ld + 2;
        while (!cdv[o_cd]) o_cd++;
        o_end = o_cd + XD + 1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NW; i++) begin
                push(d, 0, c + 1 + i, (wb(d) + i) % 512, 0);
                push(d, 2, c + 2 + i, 0, 0);
                push(d, 4, c + 2 + i, 0, 0);
            end
            for (int i = 0; i < NI; i++) begin
                push(d, 1, c + NW + 1 + i, (ab(d) + i) % 512, 0);
                push(d, 3, c + NW + 2 + i, 0, 0);
                push(d, 5, c + NW + 2 + i, 0, 0);
            end
            push(d, 6, c + o_ld + 1, 0, 0);
            for (int k = 0; k < XD; k++)
                push(d, 7, c + o_cd + 1 + k, (pb(d) + k) % 512, int'(pev[o_cd][k]));
            push(d, 8, c + o_end, 0, 0);
        end
        busy_lo = c + 1;
        busy_hi = c + o_end;
        for (int o = 0; o <= o_end + 1; o++) begin
            go = (o == 0) ? 1'b1 : (o <= o_end ? gov[o] : 1'b0);
            load_done = ldv[o];
            compute_done = cdv[o];
            pe_out = pev[o];
            if (o == rst_at) begin
                do_reset;
                return;
            end
            tick;
        end
        go = 1'b0;
        load_done = 1'b0;
        compute_done = 1'b0;
    endtask

    initial begin
        tick;
        tick;
        reset = 1'b0;
        tick;
        run_pass(0, -1);
        run_pass(1, -1);
        run_pass(2, 20);
        for (int n = 0; n < 6; n++)
            run_pass(2, -1);
        repeat (3) tick;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < NK; k++)
                cmp($sformatf("dut%0d %s events left over", d, kname[k]), q[d][k].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cluster_load_ctrl.md
CLUSTER_LOAD_CTRL -- requirements
Module: cluster_load_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 16, data word width.
- ADDR_WIDTH, default 9, GLB address width.
- X_dim, default 3, PE columns and psum words per pass.
- NUM_WGHT, default 9, weight words per pass.
- NUM_IACT, default 25, iact words per pass.
- W_READ_ADDR, default 0, first weight GLB address.
- A_READ_ADDR, default 0, first iact GLB address.
- PSUM_LOAD_ADDR, default 0, first psum GLB write address.
REQ-002 Ports SHALL be as follows (one clock `clk`; reset `reset` is asynchronous and active-high):
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- go  in  1  start one pass (sampled in IDLE only).
- read_req_wght, read_req_iact  out  1  GLB read strobes.
- r_addr_wght, r_addr_iact  out  ADDR_WIDTH  GLB read addresses.
- west_enable_i_wght, west_enable_i_iact  out  1  router west-source valids.
- load_en_wght, load_en_act  out  1  PE-cluster load strobes.
- load_done  in  1  PE cluster finished loading.
- start  out  1  compute start pulse.
- compute_done  in  1  PE cluster finished computing.
- pe_out  in  X_dim x DATA_WIDTH  PE column results.
- west_data_i_psum  out  DATA_WIDTH  psum word to router.
- west_enable_i_psum  out  1  psum valid to router.
- w_addr_psum  out  ADDR_WIDTH  GLB psum write address.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle end-of-pass pulse.

Function
REQ-003 The FSM SHALL have states IDLE, LD_WGHT, LD_IACT, WAIT_LOAD, START, COMPUTE, WRBACK, DONE.
REQ-004 The FSM SHALL move from IDLE to LD_WGHT on go=1, and SHALL ignore go in every other state.
REQ-005 LD_WGHT SHALL last exactly NUM_WGHT cycles, asserting read_req_wght=1 with r_addr_wght=W_READ_ADDR+i for i=0..NUM_WGHT-1, then go to LD_IACT.
REQ-006 LD_IACT SHALL last exactly NUM_IACT cycles, asserting read_req_iact=1 with r_addr_iact=A_READ_ADDR+i, then go to WAIT_LOAD.
REQ-007 The GLB read latency SHALL be taken as 1 cycle.
REQ-008 west_enable_i_wght and load_en_wght SHALL equal read_req_wght delayed by one cycle; west_enable_i_iact and load_en_act SHALL equal read_req_iact delayed by one cycle.
REQ-009 WAIT_LOAD SHALL stay until load_done=1 and then go to START. load_done may already be high on entry.
REQ-010 START SHALL last one cycle with start=1, then go to COMPUTE.
REQ-011 COMPUTE SHALL wait for compute_done=1; in that cycle it SHALL capture all pe_out words into X_dim registers and go to WRBACK.
REQ-012 WRBACK SHALL last X_dim cycles. In cycle k it SHALL drive west_enable_i_psum=1, west_data_i_psum=captured[k] and w_addr_psum=PSUM_LOAD_ADDR+k, then go to DONE.
REQ-013 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-014 Address sums SHALL wrap modulo 2^ADDR_WIDTH.
REQ-015 Outside the states that assert them, all strobes SHALL be 0. Address and data outputs SHALL be 0 when their strobe is low.
REQ-016 If load_done or compute_done is asserted in a state that does not wait for it, it SHALL be ignored.

Reset
REQ-017 Asserting reset at any time, mid-pass included, SHALL immediately force state to IDLE and clear counters, delay flops and captured psums.
REQ-018 While reset is asserted, every output SHALL be 0.
REQ-019 Deasserting reset SHALL leave the block idle until a new go.

Structure
REQ-020 The state enum SHALL live in a shared package, hmnoc_ctrl_pkg, alongside the router direction enum.
REQ-021 A single sub-module, glb_addr_seq, SHALL be used. It is a counter with base address and length, done flag and wrap, instantiated for weight, iact and psum sequencing.

Verification
REQ-022 The bench SHALL cover these directed scenarios (default parameters):
- go at cycle 0 -> read_req_wght high in cycles 1..9 (addr 0..8); load_en_wght high in cycles 2..10; read_req_iact high in cycles 10..34.
- load_done held high from reset -> start pulses exactly once, in the cycle after WAIT_LOAD is entered.
- compute_done with pe_out={3,7,11} -> three consecutive psum writes of 3,7,11 at addrs 0,1,2, then done=1 for one cycle.
- PSUM_LOAD_ADDR=511 -> psum write addresses 511, 0, 1.
- go pulsed during COMPUTE -> no effect; exactly one pass completes.
- reset asserted in the middle of LD_IACT -> all outputs 0 at once; a new go then starts again at weight addr 0.
